// File: rtl/iq_phase_demod_if.sv
// Sample/result bundle for the I/Q phase demodulator.
// master = upstream sample source and result consumer, slave = demodulator.
interface iq_phase_demod_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_chan;
  logic [18:0] in_i;
  logic [18:0] in_q;
  logic        out_valid;
  logic        out_chan;
  logic [19:0] phase;
  logic [19:0] freq;
  logic [20:0] mag;

  modport master (
    output in_valid, in_chan, in_i, in_q,
    input  in_ready, out_valid, out_chan, phase, freq, mag
  );

  modport slave (
    input  in_valid, in_chan, in_i, in_q,
    output in_ready, out_valid, out_chan, phase, freq, mag
  );
endinterface

// File: rtl/iq_phase_demod.sv
// Two-channel time-multiplexed I/Q phase/frequency demodulator.
// Iterative vectoring CORDIC: one micro-rotation per clock, angle format
// full turn = 2^20 (same as the NCO), magnitude carries the uncorrected
// CORDIC gain. A per-channel last-phase register yields the phase step.
module iq_phase_demod #(
  parameter int unsigned ITERS = 18
) (
  input logic             clk,
  input logic             rst,
  iq_phase_demod_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_OUT
  } state_t;

  localparam logic [4:0]  K_LAST = 5'(ITERS - 1);
  localparam logic [19:0] Z_HALF = 20'h80000;

  state_t             r_state;
  logic [4:0]         r_k;
  logic signed [20:0] r_x;
  logic signed [20:0] r_y;
  logic [19:0]        r_z;
  logic               r_chan;
  logic               r_zero;
  logic [19:0]        r_last [2];

  logic signed [20:0] w_i_ext;
  logic signed [20:0] w_q_ext;
  logic signed [20:0] w_x_sh;
  logic signed [20:0] w_y_sh;
  logic signed [20:0] w_x_nxt;
  logic signed [20:0] w_y_nxt;
  logic [19:0]        w_atan;
  logic [19:0]        w_z_nxt;
  logic [19:0]        w_phase_fin;
  logic [19:0]        w_freq_fin;
  logic [20:0]        w_mag_fin;
  logic               w_in_zero;

  // atan(2^-k) / (2*pi) * 2^20, rounded
  function automatic logic [19:0] f_atan(input logic [4:0] k);
    case (k)
      5'd0:    f_atan = 20'd131072;
      5'd1:    f_atan = 20'd77376;
      5'd2:    f_atan = 20'd40884;
      5'd3:    f_atan = 20'd20753;
      5'd4:    f_atan = 20'd10417;
      5'd5:    f_atan = 20'd5213;
      5'd6:    f_atan = 20'd2607;
      5'd7:    f_atan = 20'd1304;
      5'd8:    f_atan = 20'd652;
      5'd9:    f_atan = 20'd326;
      5'd10:   f_atan = 20'd163;
      5'd11:   f_atan = 20'd81;
      5'd12:   f_atan = 20'd41;
      5'd13:   f_atan = 20'd20;
      5'd14:   f_atan = 20'd10;
      5'd15:   f_atan = 20'd5;
      5'd16:   f_atan = 20'd3;
      5'd17:   f_atan = 20'd1;
      5'd18:   f_atan = 20'd1;
      default: f_atan = '0;
    endcase
  endfunction

  // Widen the incoming sample to the 21-bit datapath
  always_comb begin
    w_i_ext   = {{2{bus.in_i[18]}}, bus.in_i};
    w_q_ext   = {{2{bus.in_q[18]}}, bus.in_q};
    w_in_zero = (bus.in_i == '0) && (bus.in_q == '0);
  end

  // One micro-rotation from the current state and the result it would give
  always_comb begin
    w_atan = f_atan(r_k);
    w_x_sh = r_x >>> r_k;
    w_y_sh = r_y >>> r_k;
    if (!r_y[20]) begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end else begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end
    w_phase_fin = r_zero ? '0 : w_z_nxt;
    w_mag_fin   = r_zero ? '0 : w_x_nxt;
    w_freq_fin  = w_phase_fin - r_last[r_chan];
  end

  // Control FSM, CORDIC state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_z           <= '0;
      r_chan        <= 1'b0;
      r_zero        <= 1'b0;
      r_last[0]     <= '0;
      r_last[1]     <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_chan  <= 1'b0;
      bus.phase     <= '0;
      bus.freq      <= '0;
      bus.mag       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_chan <= bus.in_chan;
            r_zero <= w_in_zero;
            r_k    <= '0;
            // fold the left half-plane onto the right so the rotations converge
            if (w_i_ext[20]) begin
              r_x <= -w_i_ext;
              r_y <= -w_q_ext;
              r_z <= Z_HALF;
            end else begin
              r_x <= w_i_ext;
              r_y <= w_q_ext;
              r_z <= '0;
            end
            bus.in_ready <= 1'b0;
            r_state      <= S_ROT;
          end
        end
        S_ROT: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_k <= r_k + 1'b1;
          // the last rotation feeds the output registers directly
          if (r_k == K_LAST) begin
            bus.out_valid  <= 1'b1;
            bus.out_chan   <= r_chan;
            bus.phase      <= w_phase_fin;
            bus.mag        <= w_mag_fin;
            bus.freq       <= w_freq_fin;
            r_last[r_chan] <= w_phase_fin;
            r_state        <= S_OUT;
          end
        end
        S_OUT: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_phase_demod.sv
// Self-checking bench for iq_phase_demod: directed cases plus randomized
// samples scored against an ideal atan2/sqrt model with per-case tolerances.
module tb_iq_phase_demod;
  localparam int unsigned ITERS = 18;
  localparam real         PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  iq_phase_demod_if bus ();

  iq_phase_demod #(.ITERS(ITERS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ch;
    int   exp_ph;
    int   exp_mag;
    int   tol_ph;
    int   tol_mag;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   g_tol_ph;
  int   g_tol_mag;
  int   out_pulses = 0;
  int   last_ph [2];
  int   last_tol[2];
  real  gain;
  exp_t exp_q[$];
  exp_t m_e;
  int   m_i;
  int   m_q;
  int   m_f;

  // Compare obs to exp within +/-tol; wrap selects mod-2^20 distance
  task automatic chk(input string tag, input int obs, input int exp, input int tol, input bit wrap);
    int d;
    n_chk++;
    d = obs - exp;
    if (wrap) begin
      d = d & 'hFFFFF;
      if (d >= 'h80000) d = d - 'h100000;
    end
    if (d > tol || d < -tol) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
    end
  endtask

  function automatic int ideal_phase(input int i, input int q);
    real a;
    int  p;
    a = $atan2(real'(q), real'(i));
    p = int'(a / (2.0 * PI) * 1048576.0);
    return p & 'hFFFFF;
  endfunction

  function automatic real cordic_gain(input int unsigned n);
    real g;
    real t;
    g = 1.0;
    t = 1.0;
    for (int unsigned k = 0; k < n; k++) begin
      g = g * $sqrt(1.0 + t);
      t = t / 4.0;
    end
    return g;
  endfunction

  task automatic ang_iq(input int ang, input int amp, output int i, output int q);
    real a;
    a = 2.0 * PI * real'(ang) / 1048576.0;
    i = int'(real'(amp) * $cos(a));
    q = int'(real'(amp) * $sin(a));
  endtask

  // Scoreboard: queue accepted samples, score each out_valid pulse
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_ph[0]  = 0;
      last_ph[1]  = 0;
      last_tol[0] = 0;
      last_tol[1] = 0;
    end else begin
      if (bus.out_valid) begin
        out_pulses++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0, 0, 1'b0);
        end else begin
          m_e = exp_q.pop_front();
          m_f = (m_e.exp_ph - last_ph[m_e.ch]) & 'hFFFFF;
          chk("out_chan", int'(bus.out_chan), int'(m_e.ch), 0, 1'b0);
          chk("phase", int'(bus.phase), m_e.exp_ph, m_e.tol_ph, 1'b1);
          chk("mag", int'(bus.mag), m_e.exp_mag, m_e.tol_mag, 1'b0);
          chk("freq", int'(bus.freq), m_f, m_e.tol_ph + last_tol[m_e.ch], 1'b1);
          last_ph[m_e.ch]  = m_e.exp_ph;
          last_tol[m_e.ch] = m_e.tol_ph;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m_i         = $signed(bus.in_i);
        m_q         = $signed(bus.in_q);
        m_e.ch      = bus.in_chan;
        m_e.exp_ph  = ideal_phase(m_i, m_q);
        m_e.exp_mag = int'(gain * $sqrt(real'(m_i) * real'(m_i) + real'(m_q) * real'(m_q)));
        m_e.tol_ph  = g_tol_ph;
        m_e.tol_mag = g_tol_mag;
        exp_q.push_back(m_e);
      end
    end
  end

  // Offer one sample, then check latency and return to ready
  task automatic send(input logic ch, input int i, input int q);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", int'(bus.in_ready), 1, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_chan  = ch;
    bus.in_i     = 19'(i);
    bus.in_q     = 19'(q);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, int'(ITERS), 0, 1'b0);
    @(posedge clk); #1;
    chk("ready_back", int'({bus.in_ready, bus.out_valid}), 2, 0, 1'b0);
  endtask

  task automatic send_ang(input logic ch, input int ang, input int amp);
    int i;
    int q;
    ang_iq(ang, amp, i, q);
    send(ch, i, q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int last_c;
    int p0;
    int ri;
    int rq;

    gain         = cordic_gain(ITERS);
    g_tol_ph     = 12;
    g_tol_mag    = 16;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_chan  = 1'b0;
    bus.in_i     = '0;
    bus.in_q     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready", int'(bus.in_ready), 1, 0, 1'b0);
    chk("rst_outv", int'(bus.out_valid), 0, 0, 1'b0);
    chk("rst_chan", int'(bus.out_chan), 0, 0, 1'b0);
    chk("rst_phase", int'(bus.phase), 0, 0, 1'b0);
    chk("rst_freq", int'(bus.freq), 0, 0, 1'b0);
    chk("rst_mag", int'(bus.mag), 0, 0, 1'b0);

    // cardinal axes; truncating shifts bias x upward by a few LSB
    g_tol_ph  = 2;
    g_tol_mag = 8;
    send(1'b0, 100000, 0);
    send(1'b0, 0, 100000);
    send(1'b0, -100000, 0);
    send(1'b0, 0, -100000);

    // phase steps, including a wrap through zero
    g_tol_ph  = 12;
    g_tol_mag = 16;
    send_ang(1'b0, 'h00000, 100000);
    send_ang(1'b0, 'h10000, 100000);
    send_ang(1'b0, 'hF0000, 100000);
    send_ang(1'b0, 'h10000, 100000);

    // alternating channels with opposite step directions
    for (int j = 0; j < 3; j++) begin
      send_ang(1'b0, j * 'h08000, 100000);
      send_ang(1'b1, 'h40000 - j * 'h10000, 100000);
    end

    // edge inputs: origin, most negative I, and a vector too small to resolve
    g_tol_ph  = 0;
    g_tol_mag = 0;
    send(1'b0, 0, 0);
    g_tol_ph  = 12;
    g_tol_mag = 16;
    send(1'b1, -262144, 0);
    g_tol_ph  = 'h1800;
    g_tol_mag = 32;
    send(1'b0, -1, -1);

    // randomized angles, amplitudes, channels and idle gaps
    g_tol_ph  = 12;
    g_tol_mag = 16;
    repeat (30) begin
      ang_iq(int'($urandom_range(0, 'hFFFFF)), int'($urandom_range(131072, 262000)), ri, rq);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send(1'($urandom_range(0, 1)), ri, rq);
    end

    // back-pressure: valid held high, data changing every cycle
    acc          = 0;
    last_c       = -1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ang_iq(int'($urandom_range(0, 'hFFFFF)), int'($urandom_range(131072, 262000)), ri, rq);
      bus.in_chan = 1'($urandom_range(0, 1));
      bus.in_i    = 19'(ri);
      bus.in_q    = 19'(rq);
      if (bus.in_ready) begin
        acc++;
        if (last_c >= 0) chk("bp_spacing", c - last_c, int'(ITERS) + 2, 0, 1'b0);
        last_c = c;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", acc, 3, 0, 1'b0);
    repeat (ITERS + 4) begin
      @(posedge clk); #1;
    end

    // reset at the fifth rotation edge aborts the sample
    p0 = out_pulses;
    ang_iq('h20000, 100000, ri, rq);
    bus.in_valid = 1'b1;
    bus.in_chan  = 1'b0;
    bus.in_i     = 19'(ri);
    bus.in_q     = 19'(rq);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", int'(bus.in_ready), 1, 0, 1'b0);
    chk("abort_outv", int'(bus.out_valid), 0, 0, 1'b0);
    chk("abort_phase", int'(bus.phase), 0, 0, 1'b0);
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("abort_pulses", out_pulses - p0, 0, 0, 1'b0);
    send_ang(1'b0, 'h30000, 100000);

    // reset and valid together: the sample is dropped
    p0           = out_pulses;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_chan  = 1'b1;
    bus.in_i     = 19'(50000);
    bus.in_q     = 19'(50000);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rstv_ready", int'(bus.in_ready), 1, 0, 1'b0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    chk("rstv_pulses", out_pulses - p0, 0, 0, 1'b0);
    send_ang(1'b1, 'h50000, 150000);

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("drain", exp_q.size(), 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
